// File: rtl/cut_misr_pkg.sv
// cut_misr_pkg: shared types, default constants and width check for the response MISR
package cut_misr_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} misr_state_t;

    localparam logic [31:0] MISR_POLY = 32'h04C11DB7;
    localparam logic [31:0] MISR_SEED = 32'hFFFFFFFF;

    // The response is zero-extended into the signature, so it must fit.
    function automatic bit misr_widths_ok(input int sig_w, input int resp_w);
        return sig_w >= resp_w;
    endfunction

endpackage

// File: rtl/cut_misr_step.sv
// cut_misr_step: one combinational MISR step, next = galois_shift(sig) ^ zext(resp)
//   i_sig  : current signature
//   i_resp : response vector folded in this step
//   o_next : next signature
module cut_misr_step #(
    parameter int              RESP_W = 22,
    parameter int              SIG_W  = 32,
    parameter logic [SIG_W-1:0] POLY  = cut_misr_pkg::MISR_POLY
) (
    input  logic [SIG_W-1:0]  i_sig,
    input  logic [RESP_W-1:0] i_resp,
    output logic [SIG_W-1:0]  o_next
);

    assign o_next = {i_sig[SIG_W-2:0], 1'b0} ^ (i_sig[SIG_W-1] ? POLY : '0) ^ SIG_W'(i_resp);

endmodule

// File: rtl/cut_resp_misr.sv
// cut_resp_misr: compacts a run of CUT response vectors into one MISR signature
//   clk, rst         : clock, synchronous active-high reset
//   i_start          : begins a run (ignored while busy), latches i_num_vectors
//   i_resp_*/o_resp_ready : response handshake, ready only while running
//   o_busy / o_done  : run in progress / final signature held
//   o_signature      : current MISR contents, o_vec_count: vectors accepted this run
//   i_expected/o_pass: golden compare, built only when CUT_MISR_COMPARE_EN is defined
module cut_resp_misr
    import cut_misr_pkg::*;
#(
    parameter int               RESP_W  = 22,
    parameter int               SIG_W   = 32,
    parameter logic [SIG_W-1:0] POLY    = MISR_POLY,
    parameter logic [SIG_W-1:0] SEED    = MISR_SEED,
    parameter int               COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic [COUNT_W-1:0] i_num_vectors,
    input  logic               i_resp_valid,
    output logic               o_resp_ready,
    input  logic [RESP_W-1:0]  i_resp_data,
    output logic               o_busy,
    output logic               o_done,
    output logic [SIG_W-1:0]   o_signature,
    output logic [COUNT_W-1:0] o_vec_count,
    input  logic [SIG_W-1:0]   i_expected,
    output logic               o_pass
);

    localparam bit W_OK = misr_widths_ok(SIG_W, RESP_W);

    if (!W_OK) begin : g_bad_width
        $error("cut_resp_misr: SIG_W must be >= RESP_W");
    end

    misr_state_t        r_state;
    logic [SIG_W-1:0]   r_sig;
    logic [COUNT_W-1:0] r_cnt;
    logic [COUNT_W-1:0] r_num;
    logic [SIG_W-1:0]   w_next;
    logic [COUNT_W-1:0] w_cnt_inc;
    logic               w_accept;
    logic               w_start;

    cut_misr_step #(.RESP_W(RESP_W), .SIG_W(SIG_W), .POLY(POLY)) u_step (
        .i_sig  (r_sig),
        .i_resp (i_resp_data),
        .o_next (w_next)
    );

    assign w_accept  = i_resp_valid & (r_state == RUN);
    assign w_start   = i_start & (r_state != RUN);
    assign w_cnt_inc = r_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_sig   <= SEED;
            r_cnt   <= '0;
            r_num   <= '0;
        end else if (w_start) begin
            r_state <= (i_num_vectors == '0) ? DONE : RUN;
            r_sig   <= SEED;
            r_cnt   <= '0;
            r_num   <= i_num_vectors;
        end else if (w_accept) begin
            r_sig <= w_next;
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc == r_num)
                r_state <= DONE;
        end
    end

    assign o_resp_ready = (r_state == RUN);
    assign o_busy       = (r_state == RUN);
    assign o_done       = (r_state == DONE);
    assign o_signature  = r_sig;
    assign o_vec_count  = r_cnt;

`ifdef CUT_MISR_COMPARE_EN
    logic r_pass;

    // A start leaving DONE clears pass so it never shows high outside DONE.
    always_ff @(posedge clk) begin
        if (rst)
            r_pass <= 1'b0;
        else
            r_pass <= (r_state == DONE) & ~i_start & (r_sig == i_expected);
    end

    assign o_pass = r_pass;
`else
    logic w_unused_expected;

    assign w_unused_expected = ^i_expected;
    assign o_pass            = 1'b0;
`endif

endmodule
